mc_run_ctrl: RTL and testbench
==============================

# mc_run_ctrl

Parametrised run controller for the Monte Carlo pricing datapath. It generalises the single-lane sample counter: it drives LANES parallel path-generation lanes and accepts at most `target` samples in total, trimming over-production at the boundary. It then drains in-flight lane pipelines before raising `done`. It sits between the host-interface registers (`target`, `start`, `abort`) and the lane array / sum-merge accumulators, which use `sample_accept` as their add-enable.

## Interface
- `LANES`, 4: number of parallel sample lanes (1..16).
- `CNT_W`, 32: width of sample target, sample count and cycle count.
- `FLUSH_CYC`, 8: cycles `lane_en` is held low after the last accepted sample before `done` (0 allowed).

Ports:
- `clk`  in  1  single clock, rising edge.
- `nreset`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle run request; sampled in IDLE and DONE only.
- `abort`  in  1  one-cycle cancel; wins over `start`.
- `target`  in  CNT_W  samples to accept; captured on accepted `start`.
- `sample_valid`  in  LANES  per-lane sample produced this cycle.
- `lane_en`  out  LANES  registered lane run enable (all bits equal).
- `sample_accept`  out  LANES  combinational accept mask to accumulators.
- `sample_cnt`  out  CNT_W  samples accepted in current/last run.
- `run_cycles`  out  CNT_W  cycles spent in RUN+FLUSH, saturating at all-ones.
- `busy`  out  1  high in RUN and FLUSH.
- `done`  out  1  high in DONE; cleared by `start` or `abort`.

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + `start` (no `abort`): latch `target`, clear `sample_cnt`, `run_cycles`, flush counter. If `target`==0, go to FLUSH; otherwise go to RUN.
- RUN: `lane_en` all ones. `remaining = target_q - sample_cnt`. `sample_accept` = the lowest-indexed set bits of `sample_valid`, up to min(popcount, remaining). Higher-indexed excess valids are rejected and their samples are discarded.
- `sample_cnt += popcount(sample_accept)` each edge. When the new count equals `target_q`, go to FLUSH.
- FLUSH: `lane_en` zero and `sample_accept` zero. The flush counter counts FLUSH_CYC cycles, then the state goes to DONE. With FLUSH_CYC=0, RUN goes directly to DONE.
- DONE: `done`=1. `sample_cnt` and `run_cycles` hold.
- `start` in RUN/FLUSH is ignored.
- `abort` in any state goes to IDLE, `lane_en`=0 next cycle, and `done`=0. Counts hold their values for readback.
- `sample_accept` is forced zero outside RUN, regardless of `sample_valid`.
- `target_q` is stable during a run; changes on `target` are ignored until the next accepted `start`.
- Arithmetic: `remaining` is CNT_W unsigned and never negative, because `sample_cnt` ≤ `target_q` is invariant. The popcount width is clog2(LANES+1).

## Timing
- Reset (`nreset`=0 at edge): state IDLE, `lane_en`=0, `sample_cnt`=0, `run_cycles`=0, `busy`=0, `done`=0. `sample_accept`=0 follows combinationally.
- Reset mid-run has the same effect as reset, and counts are cleared.
- `start` at edge t: RUN, `lane_en` and `busy` high in cycle t+1. The first accept is possible in cycle t+1.
- Final accept in cycle k: FLUSH from k+1, `lane_en` low from k+1, `done` high from k+1+FLUSH_CYC.
- `run_cycles` increments every cycle that `busy`=1.
- `abort` and `start` in the same cycle: abort wins, and the state is IDLE.
- Accept is same-cycle combinational from `sample_valid` and registered state; there is no backpressure. Lanes must not depend on accept to advance.

## Structure
- Shared package `mc_pkg`: state encoding, CNT_W default, and the popcount width function.
- One sub-module `mc_accept_mask`: combinational priority trim of `sample_valid` to `remaining`; outputs the mask and its popcount.
- The FSM and counters stay in `mc_run_ctrl`.

## Test plan
- LANES=4, target=10, all valid every RUN cycle. Cycles 1–2 accept 4 lanes each; cycle 3 accepts only lanes 0–1 (`sample_accept`=4'b0011). `sample_cnt`=10. `done` rises FLUSH_CYC+1 cycles after cycle 3.
- target=0 with FLUSH_CYC=8: no cycle with `lane_en`=1, `done` 9 cycles after `start`, `sample_cnt`=0, `run_cycles`=8.
- Sparse valids (lane 2 only, every 3rd cycle), target=3: exactly 3 accepts on lane 2. `run_cycles` equals the RUN+FLUSH cycle count. `sample_accept` is zero in FLUSH even if `sample_valid`=4'b1111.
- `abort` on the 5th RUN cycle with target=100: `lane_en` is 0 next cycle, the state is IDLE, `done` never asserts, and `sample_cnt` holds its value (e.g. 20). A following `start` restarts from 0.
- Simultaneous `start`+`abort` in DONE: the state goes to IDLE with `done`=0. `start` during RUN has no effect on `target_q` or `sample_cnt`.
- `nreset` low for one cycle mid-FLUSH: all outputs take their reset values next cycle, and there is no `done`.

Source files
------------

// File: rtl/mc_run_ctrl_pkg.sv
// mc_pkg: shared definitions for the Monte Carlo run controller.
//   state_t    - run controller FSM encoding
//   CNT_W_DEF  - default width of target / sample count / cycle count
//   pop_w()    - bits needed to hold a popcount of 0..lanes
package mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 32;

  function automatic int pop_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

endpackage

// File: rtl/mc_run_ctrl_if.sv
// mc_run_ctrl_if: host-register and lane-array signals of the run controller.
//   master : host/lane side (drives start, abort, target, sample_valid)
//   slave  : controller side (drives lane_en, sample_accept, counters, status)
interface mc_run_ctrl_if
  import mc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] target;
  logic [LANES-1:0] sample_valid;
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] sample_accept;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] run_cycles;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, target, sample_valid,
    input  lane_en, sample_accept, sample_cnt, run_cycles, busy, done
  );

  modport slave (
    input  start, abort, target, sample_valid,
    output lane_en, sample_accept, sample_cnt, run_cycles, busy, done
  );

endinterface

// File: rtl/mc_run_ctrl_accept_mask.sv
// mc_accept_mask: priority trim of per-lane valids to the remaining budget.
//   valid     in  LANES  per-lane sample produced this cycle
//   remaining in  CNT_W  samples still allowed (0 blocks everything)
//   mask      out LANES  lowest-indexed valids, at most `remaining` of them
//   count     out PW     popcount of mask
module mc_accept_mask
  import mc_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PW    = pop_w(LANES)
) (
  input  logic [LANES-1:0] valid,
  input  logic [CNT_W-1:0] remaining,
  output logic [LANES-1:0] mask,
  output logic [PW-1:0]    count
);

  // Walk lanes from index 0 upward; a lane is taken while the running
  // total is still below the budget, so excess valids fall off the top.
  always_comb begin
    mask  = '0;
    count = '0;
    for (int i = 0; i < LANES; i++) begin
      if (valid[i] && (CNT_W'(count) < remaining)) begin
        mask[i] = 1'b1;
        count   = count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_run_ctrl.sv
// mc_run_ctrl: run controller for the Monte Carlo lane array.
// Accepts exactly `target` samples across LANES lanes, then holds the lanes
// off for FLUSH_CYC cycles to drain their pipelines before raising done.
//   clk     in  clock, rising edge
//   nreset  in  synchronous active-low reset
//   bus     slave modport: start/abort/target/sample_valid in;
//           lane_en/sample_accept/sample_cnt/run_cycles/busy/done out
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; counts hold last run's values
// ST_RUN   | lanes enabled, accepting samples until target reached
// ST_FLUSH | lanes disabled, counting FLUSH_CYC drain cycles
// ST_DONE  | run complete, done high; counts hold until next start
module mc_run_ctrl
  import mc_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int FLUSH_CYC = 8
) (
  input  logic          clk,
  input  logic          nreset,
  mc_run_ctrl_if.slave  bus
);

  localparam int PW = pop_w(LANES);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);
  localparam bit NO_FLUSH = (FLUSH_CYC == 0);

  state_t           state;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] run_cycles;
  logic [FW-1:0]    flush_cnt;
  logic [LANES-1:0] lane_en;
  logic             busy;
  logic             done;

  logic [CNT_W-1:0] remaining;
  logic [LANES-1:0] acc_mask;
  logic [PW-1:0]    acc_cnt;
  logic [CNT_W-1:0] cnt_next;

  // A zero budget outside RUN forces the accept mask to zero.
  assign remaining = (state == ST_RUN) ? (target_q - sample_cnt) : '0;
  assign cnt_next  = sample_cnt + CNT_W'(acc_cnt);

  mc_accept_mask #(
    .LANES (LANES),
    .CNT_W (CNT_W),
    .PW    (PW)
  ) u_accept_mask (
    .valid     (bus.sample_valid),
    .remaining (remaining),
    .mask      (acc_mask),
    .count     (acc_cnt)
  );

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state      <= ST_IDLE;
      target_q   <= '0;
      sample_cnt <= '0;
      run_cycles <= '0;
      flush_cnt  <= '0;
      lane_en    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // busy is registered with the state, so it marks RUN/FLUSH cycles.
      if (busy && (run_cycles != '1)) begin
        run_cycles <= run_cycles + 1'b1;
      end
      // Samples accepted in the abort cycle still reached the accumulators.
      if (state == ST_RUN) begin
        sample_cnt <= cnt_next;
      end

      if (bus.abort) begin
        state   <= ST_IDLE;
        lane_en <= '0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              target_q   <= bus.target;
              sample_cnt <= '0;
              run_cycles <= '0;
              if (bus.target != '0) begin
                state   <= ST_RUN;
                lane_en <= '1;
                busy    <= 1'b1;
                done    <= 1'b0;
              end else if (NO_FLUSH) begin
                state   <= ST_DONE;
                lane_en <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
                lane_en   <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
              end
            end
          end
          ST_RUN: begin
            if (cnt_next == target_q) begin
              lane_en <= '0;
              if (NO_FLUSH) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= ST_FLUSH;
                flush_cnt <= FLUSH_LOAD;
              end
            end
          end
          ST_FLUSH: begin
            if (flush_cnt == '0) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            lane_en <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lane_en       = lane_en;
  assign bus.sample_accept = acc_mask;
  assign bus.sample_cnt    = sample_cnt;
  assign bus.run_cycles    = run_cycles;
  assign bus.busy          = busy;
  assign bus.done          = done;

endmodule

// File: tb/tb_mc_run_ctrl.sv
// tb_mc_run_ctrl: directed, self-checking bench for mc_run_ctrl
// (LANES=4, CNT_W=32, FLUSH_CYC=8).
module tb_mc_run_ctrl;

  localparam int LANES = 4;
  localparam int CNT_W = 32;
  localparam int FLUSH = 8;

  typedef struct {
    logic        start;
    logic        abort;
    logic [31:0] target;
    logic [3:0]  valid;
    logic        e_en;
    logic [3:0]  e_acc;
    logic [31:0] e_cnt;
    logic [31:0] e_rc;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_run_ctrl_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  mc_run_ctrl #(
    .LANES     (LANES),
    .CNT_W     (CNT_W),
    .FLUSH_CYC (FLUSH)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic st, input logic ab, input logic [31:0] tg,
                              input logic [3:0] vl, input logic en, input logic [3:0] acc,
                              input logic [31:0] cnt, input logic [31:0] rc,
                              input logic bsy, input logic dn);
    vec_t v;
    v.start = st; v.abort = ab; v.target = tg; v.valid = vl;
    v.e_en = en; v.e_acc = acc; v.e_cnt = cnt; v.e_rc = rc;
    v.e_busy = bsy; v.e_done = dn;
    return v;
  endfunction

  vec_t vecs[14];
  int   first_done;
  int   busy_n;
  int   acc2;
  int   flush_bad;
  logic saw_en;
  logic saw_done;
  logic [3:0] other_acc;

  initial begin
    // target=10, all lanes valid: 4 + 4 + 2 accepts, then 8 flush cycles.
    vecs[0]  = mk(1, 0, 10, 4'h0, 0, 4'h0,  0,  0, 0, 0);
    vecs[1]  = mk(0, 0,  0, 4'hf, 1, 4'hf,  0,  0, 1, 0);
    vecs[2]  = mk(0, 0, 55, 4'hf, 1, 4'hf,  4,  1, 1, 0);
    vecs[3]  = mk(0, 0,  0, 4'hf, 1, 4'h3,  8,  2, 1, 0);
    for (int i = 4; i <= 11; i++)
      vecs[i] = mk(0, 0, 0, 4'hf, 0, 4'h0, 10, 32'(i - 1), 1, 0);
    vecs[12] = mk(0, 0,  0, 4'hf, 0, 4'h0, 10, 11, 0, 1);
    vecs[13] = mk(0, 0,  0, 4'h0, 0, 4'h0, 10, 11, 0, 1);

    bus.start = 1'b0; bus.abort = 1'b0; bus.target = '0; bus.sample_valid = '0;
    nreset = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("reset_lane_en", 32'(bus.lane_en), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    next_cyc();
    nreset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      bus.target = vecs[i].target;
      bus.sample_valid = vecs[i].valid;
      @(negedge clk);
      chk($sformatf("v%0d_lane_en", i), 32'(bus.lane_en), vecs[i].e_en ? 32'hf : 32'h0);
      chk($sformatf("v%0d_accept", i), 32'(bus.sample_accept), 32'(vecs[i].e_acc));
      chk($sformatf("v%0d_cnt", i), bus.sample_cnt, vecs[i].e_cnt);
      chk($sformatf("v%0d_run_cycles", i), bus.run_cycles, vecs[i].e_rc);
      chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
      next_cyc();
    end

    // target=0 from DONE: straight to FLUSH, done 9 cycles after start.
    bus.start = 1'b1; bus.target = 0; bus.sample_valid = 4'hf;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0;
    first_done = 0; saw_en = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.lane_en != 0 || bus.sample_accept != 0) saw_en = 1'b1;
      if (bus.done && first_done == 0) first_done = n;
      next_cyc();
    end
    chk("t0_lane_en_seen", 32'(saw_en), 0);
    chk("t0_done_cycle", 32'(first_done), 9);
    chk("t0_cnt", bus.sample_cnt, 0);
    chk("t0_run_cycles", bus.run_cycles, 8);

    // Sparse valids on lane 2 every 3rd RUN cycle, target=3; all valid in FLUSH.
    bus.start = 1'b1; bus.target = 3; bus.sample_valid = 4'h0;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0;
    first_done = 0; busy_n = 0; acc2 = 0; flush_bad = 0; other_acc = '0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.busy && bus.lane_en == 0) bus.sample_valid = 4'hf;
      else if (bus.lane_en != 0 && (n % 3) == 1) bus.sample_valid = 4'b0100;
      else bus.sample_valid = 4'h0;
      @(negedge clk);
      if (bus.busy) busy_n++;
      acc2 += int'(bus.sample_accept[2]);
      other_acc |= bus.sample_accept & 4'b1011;
      if (bus.busy && bus.lane_en == 0 && bus.sample_accept != 0) flush_bad++;
      if (bus.done && first_done == 0) first_done = n;
      next_cyc();
    end
    bus.sample_valid = 4'h0;
    chk("sp_lane2_accepts", 32'(acc2), 3);
    chk("sp_other_lanes", 32'(other_acc), 0);
    chk("sp_flush_accept", 32'(flush_bad), 0);
    chk("sp_done_cycle", 32'(first_done), 16);
    chk("sp_busy_cycles", 32'(busy_n), 15);
    chk("sp_run_cycles", bus.run_cycles, 15);
    chk("sp_cnt", bus.sample_cnt, 3);

    // Abort on the 5th RUN cycle, target=100.
    bus.start = 1'b1; bus.target = 100; bus.sample_valid = 4'hf;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) bus.abort = 1'b1;
      @(negedge clk);
      if (n == 5) chk("ab_cnt_before", bus.sample_cnt, 16);
      next_cyc();
    end
    bus.abort = 1'b0;
    @(negedge clk);
    chk("ab_lane_en", 32'(bus.lane_en), 0);
    chk("ab_busy", 32'(bus.busy), 0);
    chk("ab_done", 32'(bus.done), 0);
    chk("ab_accept", 32'(bus.sample_accept), 0);
    chk("ab_cnt_hold", bus.sample_cnt, 20);
    chk("ab_run_cycles", bus.run_cycles, 5);
    next_cyc();
    saw_done = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
      next_cyc();
    end
    chk("ab_no_done", 32'(saw_done), 0);
    chk("ab_cnt_later", bus.sample_cnt, 20);

    // Restart with target=12; a start with target=2 mid-RUN must be ignored.
    bus.start = 1'b1; bus.target = 12;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0;
    @(negedge clk);
    chk("rs_cnt_cleared", bus.sample_cnt, 0);
    chk("rs_rc_cleared", bus.run_cycles, 0);
    next_cyc();
    bus.start = 1'b1; bus.target = 2;
    @(negedge clk);
    chk("rs_cnt_c2", bus.sample_cnt, 4);
    next_cyc();
    bus.start = 1'b0;
    first_done = 0;
    for (int n = 3; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done && first_done == 0) first_done = n;
      next_cyc();
    end
    chk("rs_done_cycle", 32'(first_done), 12);
    chk("rs_cnt_final", bus.sample_cnt, 12);

    // start+abort together in DONE: IDLE, done cleared, counts kept.
    bus.start = 1'b1; bus.abort = 1'b1; bus.target = 5;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    chk("sa_done", 32'(bus.done), 0);
    chk("sa_busy", 32'(bus.busy), 0);
    chk("sa_lane_en", 32'(bus.lane_en), 0);
    chk("sa_cnt_hold", bus.sample_cnt, 12);
    next_cyc();
    @(negedge clk);
    chk("sa_still_idle", 32'(bus.busy), 0);
    next_cyc();

    // Reset pulse mid-FLUSH.
    bus.start = 1'b1; bus.target = 4; bus.sample_valid = 4'hf;
    @(negedge clk);
    next_cyc();
    bus.start = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      if (n == 3) nreset = 1'b0;
      @(negedge clk);
      if (n == 2) chk("rf_in_flush", 32'({bus.busy, bus.lane_en}), 32'h10);
      next_cyc();
    end
    nreset = 1'b1;
    @(negedge clk);
    chk("rf_lane_en", 32'(bus.lane_en), 0);
    chk("rf_accept", 32'(bus.sample_accept), 0);
    chk("rf_cnt", bus.sample_cnt, 0);
    chk("rf_run_cycles", bus.run_cycles, 0);
    chk("rf_busy", 32'(bus.busy), 0);
    chk("rf_done", 32'(bus.done), 0);
    next_cyc();
    saw_done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
      next_cyc();
    end
    chk("rf_no_done", 32'(saw_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
